// File: rtl/pb_pkg.sv
// pb_pkg: shared button indices, channel FSM states and one-hot heading constants.
package pb_pkg;
  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_UP    = 3;
  localparam int BTN_MODE  = 4;
  localparam int BTN_KEY   = 5;
  localparam int BTN_OBS   = 6;
  typedef enum logic [1:0] {IDLE, ARM_PRESS, HELD, ARM_RELEASE} pb_state_t;
  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0001;
  function automatic logic [3:0] dir_opposite(input logic [3:0] d);
    return {d[2], d[3], d[0], d[1]};
  endfunction
endpackage

// File: rtl/pb_debounce_ch.sv
// pb_debounce_ch: 2-FF synchronizer plus debounce FSM for one button, with registered level and edge pulses.
module pb_debounce_ch
  import pb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync_ff;
  logic sync;
  logic done;
  pb_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic level_n, press_n, rel_n;
  assign sync = sync_ff[1];
  assign done = cnt == LAST;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff <= '0;
      state   <= IDLE;
      cnt     <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
      rel     <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], raw};
      state   <= state_n;
      cnt     <= cnt_n;
      level   <= level_n;
      press   <= press_n;
      rel     <= rel_n;
    end
  end
  // Counter restarts at 1 on the first differing sample, so DEBOUNCE_CYCLES stable samples are required.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (sync) begin
        state_n = ARM_PRESS;
        cnt_n   = CNT_W'(1);
      end
      ARM_PRESS: if (!sync) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else if (done) begin
        state_n = HELD;
        cnt_n   = '0;
      end else cnt_n = cnt + CNT_W'(1);
      HELD: if (!sync) begin
        state_n = ARM_RELEASE;
        cnt_n   = CNT_W'(1);
      end
      ARM_RELEASE: if (sync) begin
        state_n = HELD;
        cnt_n   = '0;
      end else if (done) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else cnt_n = cnt + CNT_W'(1);
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end
  always_comb begin
    press_n = (state == ARM_PRESS) && sync && done;
    rel_n   = (state == ARM_RELEASE) && !sync && done;
    level_n = press_n | (level & ~rel_n);
  end
endmodule

// File: rtl/pb_conditioner.sv
// pb_conditioner: per-button debounce channels plus a direction arbiter that refuses 180-degree reversals.
module pb_conditioner
  import pb_pkg::*;
#(
  parameter int N_BTN = 7,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] pb_raw,
  output logic [N_BTN-1:0] pb_level,
  output logic [N_BTN-1:0] pb_press,
  output logic [N_BTN-1:0] pb_release,
  output logic [3:0]       dir,
  output logic             dir_changed
);
  logic [3:0] cand;
  logic accept;
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    pb_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W(CNT_W)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .raw(pb_raw[i]),
      .level(pb_level[i]),
      .press(pb_press[i]),
      .rel(pb_release[i])
    );
  end
  // Only the top-priority press is considered; a rejected one never falls through.
  always_comb begin
    cand = pb_press[BTN_UP]    ? DIR_UP :
           pb_press[BTN_DOWN]  ? DIR_DOWN :
           pb_press[BTN_RIGHT] ? DIR_RIGHT :
           pb_press[BTN_LEFT]  ? DIR_LEFT : 4'b0000;
    accept = (|cand) && (cand != dir) && (cand != dir_opposite(dir));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir         <= DIR_RIGHT;
      dir_changed <= 1'b0;
    end else begin
      dir_changed <= accept;
      if (accept) dir <= cand;
    end
  end
endmodule
